reservation_station: RTL and testbench
======================================

// Module: reservation_station
// PURPOSE
// - Per-functional-unit Tomasulo reservation station, directly downstream of decode/issue.
// - Accepts one issue packet per cycle into a free slot and snoops the CDB to wake waiting operands.
// - Selects the oldest fully-ready entry and hands it to its FU through a registered valid/ready dispatch port.
// - Instantiated four times (ALU, MULT, DIV, MEM). Its full_o feeds the matching rs_*_full_i of the issue stage.
// PARAMETERS
// - NUM_ENTRIES  4  slots in the station (2..8).
// - TAG_W        4  ROB tag width; must match the width of the ROB tail and the cdb_packet_s rob_entry field.
// PORTS
// - clk_i             in   1    single clock; all state updates on the rising edge
// - reset_i           in   1    synchronous, active-high reset
// - flush_i           in   1    mispredict flush; discards all entries and the output register
// - issue_valid_i     in   1    write issue_packet_i into a free slot this cycle
// - issue_packet_i    in   reservation_station_s  busy/op/qj/qk/vj/vk/dest/address/fu_type/pc
// - full_o            out  1    all slots busy (combinational from current state)
// - occupancy_o       out  $clog2(NUM_ENTRIES+1)  count of busy slots
// - cdb_packet_i      in   cdb_packet_s  broadcast result: valid/exception/rob_entry/data
// - dispatch_valid_o  out  1    output register holds an instruction for the FU
// - dispatch_ready_i  in   1    FU accepts; transfer = valid && ready
// - dispatch_op_o     out  4    opcode
// - dispatch_vj_o     out  32   operand 1
// - dispatch_vk_o     out  32   operand 2 (immediate for ADDI/LW)
// - dispatch_imm_o    out  32   address/immediate field
// - dispatch_dest_o   out  TAG_W  ROB tag for the result
// - dispatch_pc_o     out  32   instruction PC
// BEHAVIOUR
// - Reset: all busy=0, age matrix cleared, dispatch_valid_o=0, full_o=0, occupancy_o=0, all dispatch data outputs 0.
// - Tag encoding: q==0 means the operand is ready; a nonzero q is the ROB tag of the producer.
// - Allocate: when issue_valid_i is high and a slot is free, write the lowest-index free slot and set busy=1.
//   The new slot becomes younger than every busy slot.
// - Issue while full_o=1 is ignored (assert fires). A slot freed in the same cycle does not satisfy that issue.
// - Wakeup, in the same edge: for every busy slot with cdb.valid && !cdb.exception && qj==cdb.rob_entry,
//   set vj<=data and qj<=0. The same rule applies to qk/vk.
// - Wakeup bypass: the same CDB match applies to the incoming packet, so an issue in the CDB cycle stores the operand as ready.
// - An exception CDB never wakes an operand.
// - Select (combinational): among slots with busy && qj==0 && qk==0, pick the oldest via the age matrix.
// - The output register loads when it is empty, or when it transfers this cycle.
//   Loading clears busy of the selected slot on the same edge.
// - Latency: issue at N with ready operands -> dispatch_valid_o at N+2.
//   CDB wakeup at M -> dispatch_valid_o no earlier than M+2.
// - Throughput: with dispatch_ready_i held high, one dispatch per cycle.
// - Backpressure: while valid && !ready, all dispatch_* outputs are held stable and no slot is freed into the register.
// - Flush (priority over everything except reset): the next edge clears all busy bits and dispatch_valid_o.
//   A simultaneous issue is dropped and the CDB is ignored.
// - Reset mid-operation behaves the same as flush and also zeroes the data outputs.
// - occupancy_o counts busy slots only; the output register is not counted.
// STRUCTURE
// - Shared package (structs.svh): reservation_station_s, cdb_packet_s, FU_ALU/MULT/DIV/MEM = 2'b00..2'b11, TAG_NONE = '0.
// - Sub-module rs_age_select: an NUM_ENTRIES x NUM_ENTRIES age matrix.
//   Inputs: alloc one-hot and free one-hot. Takes the ready vector and returns the one-hot oldest plus an any-valid bit.
// - Top level: slot array, wakeup compare, free-slot priority encoder, output register.
// TESTING
// - T1 Reset: assert reset_i for 2 cycles -> full_o=0, occupancy_o=0, dispatch_valid_o=0, all outputs 0.
// - T2 Ready path: at N issue op=0, qj=qk=0, vj=5, vk=7, dest=3, with ready=1.
//   Expect valid at N+2 with vj=5, vk=7, dest=3, and occupancy 1->0.
// - T3 Wakeup: issue qj=4, qk=0, vk=1, then CDB {valid, rob=4, data=0x10} at M -> dispatch at M+2 with vj=0x10.
//   A prior CDB rob=4 with exception=1 does not wake the slot.
// - T4 Bypass: issue qk=6 in the same cycle as CDB rob=6, data=0xAB -> dispatched with vk=0xAB, no extra wait.
// - T5 Age/full: fill 4 slots (ready=0, slot 2 ready first, then slot 0) -> full_o=1.
//   Raise ready -> slot 2 dispatches before slot 0. Issue while full is ignored.
// - T6 Flush under backpressure: 3 busy slots, valid=1, ready=0, assert flush_i ->
//   next cycle valid=0, occupancy_o=0, full_o=0, and the concurrent issue is dropped.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// Shared types for the Tomasulo reservation stations: issue packet, CDB broadcast,
// functional-unit codes and the operand wakeup rule.
package reservation_station_pkg;

   localparam int RS_TAG_W = 4;
   localparam int XLEN     = 32;

   localparam logic [1:0] FU_ALU  = 2'b00;
   localparam logic [1:0] FU_MULT = 2'b01;
   localparam logic [1:0] FU_DIV  = 2'b10;
   localparam logic [1:0] FU_MEM  = 2'b11;

   localparam logic [RS_TAG_W-1:0] TAG_NONE = '0;

   typedef struct packed {
      logic                busy;
      logic [3:0]          op;
      logic [RS_TAG_W-1:0] qj;
      logic [RS_TAG_W-1:0] qk;
      logic [XLEN-1:0]     vj;
      logic [XLEN-1:0]     vk;
      logic [RS_TAG_W-1:0] dest;
      logic [XLEN-1:0]     address;
      logic [1:0]          fu_type;
      logic [XLEN-1:0]     pc;
   } reservation_station_s;

   typedef struct packed {
      logic                valid;
      logic                exception;
      logic [RS_TAG_W-1:0] rob_entry;
      logic [XLEN-1:0]     data;
   } cdb_packet_s;

   // A tag of zero already means "ready", so it can never be woken again.
   function automatic logic cdb_hit(cdb_packet_s cdb, logic [RS_TAG_W-1:0] q);
      return cdb.valid && !cdb.exception && (q != TAG_NONE) && (q == cdb.rob_entry);
   endfunction

endpackage

// File: rtl/reservation_station_age_select.sv
// Age matrix for the reservation station: older[i][j]=1 means slot i was allocated
// before slot j. Returns the oldest slot among the ready vector as a one-hot.
module rs_age_select
   import reservation_station_pkg::*;
#(
   parameter int NUM_ENTRIES = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic [NUM_ENTRIES-1:0] alloc_oh,
   input  logic [NUM_ENTRIES-1:0] free_oh,
   input  logic [NUM_ENTRIES-1:0] ready,
   output logic [NUM_ENTRIES-1:0] oldest_oh,
   output logic                   any_valid
);

   logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] older;
   logic [NUM_ENTRIES-1:0]                  beaten;

   // A new slot is younger than everything; a freed slot drops out of all orderings.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         older <= '0;
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            for (int j = 0; j < NUM_ENTRIES; j++) begin
               if (i != j) begin
                  if (alloc_oh[i] || free_oh[i] || free_oh[j])
                     older[i][j] <= 1'b0;
                  else if (alloc_oh[j])
                     older[i][j] <= 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      beaten    = '0;
      oldest_oh = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         for (int j = 0; j < NUM_ENTRIES; j++) begin
            if ((i != j) && ready[j] && !older[i][j])
               beaten[i] = 1'b1;
         end
         oldest_oh[i] = ready[i] && !beaten[i];
      end
   end

   assign any_valid = |ready;

endmodule

// File: rtl/reservation_station.sv
// Per-FU Tomasulo reservation station: slot array with CDB wakeup, oldest-ready
// select through an age matrix, and a registered valid/ready dispatch port.
module reservation_station
   import reservation_station_pkg::*;
#(
   parameter int NUM_ENTRIES = 4,
   parameter int TAG_W       = RS_TAG_W
) (
   input  logic                               clk_i,
   input  logic                               reset_i,
   input  logic                               flush_i,
   input  logic                               issue_valid_i,
   input  reservation_station_s               issue_packet_i,
   output logic                               full_o,
   output logic [$clog2(NUM_ENTRIES+1)-1:0]   occupancy_o,
   input  cdb_packet_s                        cdb_packet_i,
   output logic                               dispatch_valid_o,
   input  logic                               dispatch_ready_i,
   output logic [3:0]                         dispatch_op_o,
   output logic [31:0]                        dispatch_vj_o,
   output logic [31:0]                        dispatch_vk_o,
   output logic [31:0]                        dispatch_imm_o,
   output logic [TAG_W-1:0]                   dispatch_dest_o,
   output logic [31:0]                        dispatch_pc_o
);

   localparam int OCC_W = $clog2(NUM_ENTRIES+1);

   reservation_station_s   slot_q [NUM_ENTRIES];
   reservation_station_s   issue_woke;
   reservation_station_s   sel;
   logic [NUM_ENTRIES-1:0] busy;
   logic [NUM_ENTRIES-1:0] ready;
   logic [NUM_ENTRIES-1:0] free_slot_oh;
   logic [NUM_ENTRIES-1:0] alloc_oh;
   logic [NUM_ENTRIES-1:0] free_oh;
   logic [NUM_ENTRIES-1:0] oldest_oh;
   logic                   any_ready;
   logic                   load;
   logic                   unused_fields;

   assign full_o = &busy;

   always_comb begin
      occupancy_o = '0;
      for (int i = 0; i < NUM_ENTRIES; i++)
         occupancy_o = occupancy_o + OCC_W'(busy[i]);
   end

   // Lowest free slot: isolate the lowest set bit of ~busy (x & -x, with -x == busy+1).
   assign free_slot_oh = ~busy & (busy + 1'b1);
   assign alloc_oh     = (issue_valid_i && !full_o && !flush_i) ? free_slot_oh : '0;

   always_comb begin
      for (int i = 0; i < NUM_ENTRIES; i++)
         ready[i] = busy[i] && (slot_q[i].qj == TAG_NONE) && (slot_q[i].qk == TAG_NONE);
   end

   rs_age_select #(
      .NUM_ENTRIES (NUM_ENTRIES)
   ) u_age (
      .clk       (clk_i),
      .reset     (reset_i),
      .clear     (flush_i),
      .alloc_oh  (alloc_oh),
      .free_oh   (free_oh),
      .ready     (ready),
      .oldest_oh (oldest_oh),
      .any_valid (any_ready)
   );

   // The output register refills whenever it is empty or draining this cycle.
   assign load    = any_ready && (!dispatch_valid_o || dispatch_ready_i) && !flush_i;
   assign free_oh = load ? oldest_oh : '0;

   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_ENTRIES; i++)
         if (oldest_oh[i]) sel = slot_q[i];
   end

   // Same-cycle CDB result is folded into the packet being written.
   always_comb begin
      issue_woke      = issue_packet_i;
      issue_woke.busy = 1'b1;
      if (cdb_hit(cdb_packet_i, issue_packet_i.qj)) begin
         issue_woke.qj = TAG_NONE;
         issue_woke.vj = cdb_packet_i.data;
      end
      if (cdb_hit(cdb_packet_i, issue_packet_i.qk)) begin
         issue_woke.qk = TAG_NONE;
         issue_woke.vk = cdb_packet_i.data;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i || flush_i) begin
         busy <= '0;
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (alloc_oh[i]) begin
               slot_q[i] <= issue_woke;
               busy[i]   <= 1'b1;
            end else begin
               if (free_oh[i]) busy[i] <= 1'b0;
               if (busy[i] && cdb_hit(cdb_packet_i, slot_q[i].qj)) begin
                  slot_q[i].qj <= TAG_NONE;
                  slot_q[i].vj <= cdb_packet_i.data;
               end
               if (busy[i] && cdb_hit(cdb_packet_i, slot_q[i].qk)) begin
                  slot_q[i].qk <= TAG_NONE;
                  slot_q[i].vk <= cdb_packet_i.data;
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         dispatch_valid_o <= 1'b0;
         dispatch_op_o    <= '0;
         dispatch_vj_o    <= '0;
         dispatch_vk_o    <= '0;
         dispatch_imm_o   <= '0;
         dispatch_dest_o  <= '0;
         dispatch_pc_o    <= '0;
      end else if (flush_i) begin
         dispatch_valid_o <= 1'b0;
      end else if (load) begin
         dispatch_valid_o <= 1'b1;
         dispatch_op_o    <= sel.op;
         dispatch_vj_o    <= sel.vj;
         dispatch_vk_o    <= sel.vk;
         dispatch_imm_o   <= sel.address;
         dispatch_dest_o  <= sel.dest;
         dispatch_pc_o    <= sel.pc;
      end else if (dispatch_ready_i) begin
         dispatch_valid_o <= 1'b0;
      end
   end

   assign unused_fields = ^{sel.busy, sel.fu_type};

`ifdef RS_ASSERT_ISSUE_NOT_FULL
   // Issue into a full station is dropped; enable where the issue stage guarantees it never happens.
   always_ff @(posedge clk_i)
      if (!reset_i && !flush_i)
         assert (!(issue_valid_i && full_o)) else $error("issue while reservation station full");
`endif

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios plus random traffic, checked by an
// age-ordered queue model and a dispatch scoreboard.
module tb_reservation_station;
   import reservation_station_pkg::*;

   localparam int N     = 4;
   localparam int OCC_W = $clog2(N+1);

   logic                 clk = 1'b0;
   logic                 reset, flush, issue_valid, dispatch_ready;
   reservation_station_s pkt;
   cdb_packet_s          cdb;
   logic                 full, d_valid;
   logic [OCC_W-1:0]     occ;
   logic [3:0]           d_op;
   logic [31:0]          d_vj, d_vk, d_imm, d_pc;
   logic [RS_TAG_W-1:0]  d_dest;

   always #5 clk = ~clk;

   reservation_station #(.NUM_ENTRIES(N), .TAG_W(RS_TAG_W)) dut (
      .clk_i            (clk),
      .reset_i          (reset),
      .flush_i          (flush),
      .issue_valid_i    (issue_valid),
      .issue_packet_i   (pkt),
      .full_o           (full),
      .occupancy_o      (occ),
      .cdb_packet_i     (cdb),
      .dispatch_valid_o (d_valid),
      .dispatch_ready_i (dispatch_ready),
      .dispatch_op_o    (d_op),
      .dispatch_vj_o    (d_vj),
      .dispatch_vk_o    (d_vk),
      .dispatch_imm_o   (d_imm),
      .dispatch_dest_o  (d_dest),
      .dispatch_pc_o    (d_pc)
   );

   typedef struct {
      logic [3:0]          op;
      logic [31:0]         vj, vk, imm, pc;
      logic [RS_TAG_W-1:0] dest;
   } disp_t;

   reservation_station_s mq[$];     // waiting instructions, oldest at the front
   disp_t                exp_q[$];  // instructions the model has moved to the FU port
   logic                 m_valid = 1'b0;
   int                   passed = 0, total = 0;
   disp_t                e;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endfunction

   function automatic reservation_station_s wake(reservation_station_s x, cdb_packet_s c);
      if (c.valid && !c.exception && x.qj != 0 && x.qj == c.rob_entry) begin
         x.qj = '0; x.vj = c.data;
      end
      if (c.valid && !c.exception && x.qk != 0 && x.qk == c.rob_entry) begin
         x.qk = '0; x.vk = c.data;
      end
      return x;
   endfunction

   function automatic disp_t to_disp(reservation_station_s x);
      disp_t d;
      d.op = x.op; d.vj = x.vj; d.vk = x.vk; d.imm = x.address; d.pc = x.pc; d.dest = x.dest;
      return d;
   endfunction

   // Reference model: oldest ready instruction goes to the port when it is free or draining.
   always @(posedge clk) begin : model
      bit                   was_full;
      int                   pick;
      reservation_station_s np;
      if (reset || flush) begin
         mq.delete(); exp_q.delete(); m_valid = 1'b0;
      end else begin
         was_full = (mq.size() == N);
         pick = -1;
         for (int i = 0; i < mq.size(); i++)
            if (pick < 0 && mq[i].qj == 0 && mq[i].qk == 0) pick = i;
         if ((!m_valid || dispatch_ready) && pick >= 0) begin
            exp_q.push_back(to_disp(mq[pick]));
            mq.delete(pick);
            m_valid = 1'b1;
         end else if (dispatch_ready) begin
            m_valid = 1'b0;
         end
         for (int i = 0; i < mq.size(); i++) mq[i] = wake(mq[i], cdb);
         if (issue_valid && !was_full) begin
            np = wake(pkt, cdb);
            mq.push_back(np);
         end
      end
   end

   always @(negedge clk) begin : monitor
      if (!reset) begin
         chk("valid", 32'(d_valid), 32'(m_valid));
         chk("full", 32'(full), 32'(mq.size() == N));
         chk("occupancy", 32'(occ), 32'(mq.size()));
         if (d_valid && dispatch_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               $display("FAIL dispatch: unexpected dispatch dest=%0h, none expected", d_dest);
            end else begin
               e = exp_q.pop_front();
               chk("sb_op", 32'(d_op), 32'(e.op));
               chk("sb_vj", d_vj, e.vj);
               chk("sb_vk", d_vk, e.vk);
               chk("sb_imm", d_imm, e.imm);
               chk("sb_dest", 32'(d_dest), 32'(e.dest));
               chk("sb_pc", d_pc, e.pc);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
      issue_valid = 1'b0; flush = 1'b0; cdb = '0;
   endtask

   task automatic set_issue(input logic [3:0] op, input logic [RS_TAG_W-1:0] qj, qk,
                            input logic [31:0] vj, vk, input logic [RS_TAG_W-1:0] dest);
      pkt = '0;
      pkt.busy = 1'b1; pkt.op = op; pkt.qj = qj; pkt.qk = qk; pkt.vj = vj; pkt.vk = vk;
      pkt.dest = dest; pkt.address = vj ^ 32'h5a5a_0000; pkt.fu_type = FU_ALU;
      pkt.pc = 32'h1000 + {28'd0, dest} * 32'd4;
      issue_valid = 1'b1;
   endtask

   task automatic set_cdb(input logic exc, input logic [RS_TAG_W-1:0] rob, input logic [31:0] data);
      cdb.valid = 1'b1; cdb.exception = exc; cdb.rob_entry = rob; cdb.data = data;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; issue_valid = 1'b0; pkt = '0; cdb = '0; dispatch_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      // T1 reset
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_occ", 32'(occ), 32'd0);
      chk("rst_valid", 32'(d_valid), 32'd0);
      chk("rst_data", d_vj | d_vk | d_imm | d_pc | 32'(d_op) | 32'(d_dest), 32'd0);
      reset = 1'b0;

      // T2 ready path
      dispatch_ready = 1'b1;
      set_issue(4'h0, 4'd0, 4'd0, 32'd5, 32'd7, 4'd3); tick();
      chk("t2_occ_n1", 32'(occ), 32'd1);
      chk("t2_valid_n1", 32'(d_valid), 32'd0);
      tick();
      chk("t2_valid_n2", 32'(d_valid), 32'd1);
      chk("t2_vj", d_vj, 32'd5);
      chk("t2_vk", d_vk, 32'd7);
      chk("t2_dest", 32'(d_dest), 32'd3);
      chk("t2_occ_n2", 32'(occ), 32'd0);
      tick();
      chk("t2_valid_n3", 32'(d_valid), 32'd0);

      // T3 wakeup; an exception broadcast must not wake
      set_issue(4'h1, 4'd4, 4'd0, 32'h99, 32'd1, 4'd5); tick();
      set_cdb(1'b1, 4'd4, 32'h77); tick();
      tick();
      chk("t3_exc_nowake", 32'(d_valid), 32'd0);
      chk("t3_exc_occ", 32'(occ), 32'd1);
      set_cdb(1'b0, 4'd4, 32'h10); tick();
      chk("t3_valid_m1", 32'(d_valid), 32'd0);
      tick();
      chk("t3_valid_m2", 32'(d_valid), 32'd1);
      chk("t3_vj", d_vj, 32'h10);
      chk("t3_vk", d_vk, 32'd1);
      tick();

      // T4 bypass
      set_cdb(1'b0, 4'd6, 32'hAB);
      set_issue(4'h2, 4'd0, 4'd6, 32'd3, 32'd0, 4'd7); tick();
      chk("t4_valid_n1", 32'(d_valid), 32'd0);
      tick();
      chk("t4_valid_n2", 32'(d_valid), 32'd1);
      chk("t4_vk", d_vk, 32'hAB);
      chk("t4_dest", 32'(d_dest), 32'd7);
      tick();

      // T5 age order and full
      dispatch_ready = 1'b0;
      set_issue(4'h3, 4'd2, 4'd0, 32'd0, 32'd0, 4'd1); tick();
      set_issue(4'h3, 4'd9, 4'd0, 32'd0, 32'd0, 4'd2); tick();
      set_issue(4'h3, 4'd3, 4'd0, 32'd0, 32'd0, 4'd3); tick();
      set_issue(4'h3, 4'd9, 4'd0, 32'd0, 32'd0, 4'd4); tick();
      chk("t5_full", 32'(full), 32'd1);
      chk("t5_occ4", 32'(occ), 32'd4);
      set_issue(4'h4, 4'd0, 4'd0, 32'd1, 32'd1, 4'hF); tick();
      chk("t5_drop_occ", 32'(occ), 32'd4);
      chk("t5_drop_valid", 32'(d_valid), 32'd0);
      set_cdb(1'b0, 4'd3, 32'h33); tick();
      set_cdb(1'b0, 4'd2, 32'h22); tick();
      chk("t5_first_valid", 32'(d_valid), 32'd1);
      chk("t5_first_dest", 32'(d_dest), 32'd3);
      chk("t5_occ3", 32'(occ), 32'd3);
      dispatch_ready = 1'b1; tick();
      chk("t5_second_dest", 32'(d_dest), 32'd1);
      chk("t5_second_vj", d_vj, 32'h22);
      set_cdb(1'b0, 4'd9, 32'h99); tick();
      chk("t5_gap_valid", 32'(d_valid), 32'd0);
      tick();
      chk("t5_third_dest", 32'(d_dest), 32'd2);
      tick();
      chk("t5_fourth_dest", 32'(d_dest), 32'd4);
      tick();
      chk("t5_empty_valid", 32'(d_valid), 32'd0);
      chk("t5_empty_occ", 32'(occ), 32'd0);

      // T6 flush under backpressure
      dispatch_ready = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         set_issue(4'h5, 4'd0, 4'd0, 32'(k), 32'(k), RS_TAG_W'(k)); tick();
      end
      chk("t6_pre_valid", 32'(d_valid), 32'd1);
      chk("t6_pre_occ", 32'(occ), 32'd3);
      flush = 1'b1;
      set_issue(4'h6, 4'd0, 4'd0, 32'd9, 32'd9, 4'd9); tick();
      chk("t6_valid", 32'(d_valid), 32'd0);
      chk("t6_occ", 32'(occ), 32'd0);
      chk("t6_full", 32'(full), 32'd0);
      tick();
      chk("t6_dropped_occ", 32'(occ), 32'd0);
      chk("t6_dropped_valid", 32'(d_valid), 32'd0);

      // Random traffic, including a mid-run reset and occasional flushes
      for (int c = 0; c < 3000; c++) begin
         reset = (c == 1500);
         dispatch_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 1) == 1) begin
            set_issue(4'($urandom_range(0, 15)),
                      ($urandom_range(0, 2) == 0) ? RS_TAG_W'($urandom_range(1, 7)) : 4'd0,
                      ($urandom_range(0, 2) == 0) ? RS_TAG_W'($urandom_range(1, 7)) : 4'd0,
                      $urandom(), $urandom(), RS_TAG_W'($urandom_range(0, 15)));
            pkt.address = $urandom();
            pkt.pc      = $urandom();
         end
         if ($urandom_range(0, 9) < 4)
            set_cdb($urandom_range(0, 9) == 0, RS_TAG_W'($urandom_range(1, 7)), $urandom());
         flush = ($urandom_range(0, 99) == 0);
         tick();
      end
      reset = 1'b0;

      // Drain: wake every tag and let the port empty
      dispatch_ready = 1'b1;
      for (int t = 1; t < 16; t++) begin
         set_cdb(1'b0, RS_TAG_W'(t), 32'(t * 3));
         tick();
      end
      repeat (10) tick();
      chk("drain_occ", 32'(occ), 32'd0);
      chk("drain_valid", 32'(d_valid), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
